// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO read arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int STAT_W = 16;

endpackage

// File: rtl/fifo_read_arbiter_rr_pick.sv
// Rotate-priority selector: first asserted request at or above ptr, wrapping modulo NCH.
module rr_pick #(
  parameter int NCH = 4,
  parameter int PW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [PW-1:0]  ptr,
  output logic [PW-1:0]  idx,
  output logic           found
);

  int            c;
  logic [PW-1:0] cand;

  // Walk from the farthest candidate down so the nearest one is written last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    c     = 0;
    cand  = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      c = int'(ptr) + k;
      if (c >= NCH) c = c - NCH;
      cand = PW'(c);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_read_arbiter.sv
// Round-robin burst arbiter draining NCH async-FIFO read ports into one valid/ready stream.
// Optional per-channel pop statistics are enabled with the FIFO_ARB_STATS_EN macro.
//
//   state | meaning
//   IDLE  | pick next non-empty channel from rr_ptr, one cycle between grants
//   GRANT | pop channel g up to BURST words while it is non-empty
module fifo_read_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int DSIZE = 8,
  parameter int BURST = 4
) (
  input  logic                   rclk,
  input  logic                   rrst_n,
  input  logic [NCH-1:0]         rempty,
  input  logic [NCH*DSIZE-1:0]   rdata,
  output logic [NCH-1:0]         rout,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DSIZE-1:0]       m_data,
  output logic [$clog2(NCH)-1:0] m_chan
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NCH*STAT_W-1:0]  pop_cnt
`endif
);

  localparam int PW = $clog2(NCH);
  localparam int CW = $clog2(BURST) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);
  localparam logic [PW-1:0] CH_LAST  = PW'(NCH - 1);

  arb_state_t    state, state_nxt;
  logic [PW-1:0] g, g_nxt;
  logic [PW-1:0] rr_ptr, rr_ptr_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [PW-1:0] pick_idx;
  logic          pick_found;
  logic          space;
  logic          pop;
  logic [PW-1:0] g_succ;

  logic [DSIZE-1:0] chan_data [NCH];

  for (genvar i = 0; i < NCH; i++) begin : g_split
    assign chan_data[i] = rdata[i*DSIZE +: DSIZE];
  end

  rr_pick #(.NCH(NCH), .PW(PW)) u_pick (
    .req   (~rempty),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign space  = !m_valid || m_ready;
  assign pop    = (state == GRANT) && !rempty[g] && space;
  assign g_succ = (g == CH_LAST) ? '0 : g + 1'b1;

  always_comb begin
    rout = '0;
    if (pop) rout[g] = 1'b1;
  end

  always_comb begin
    state_nxt  = state;
    g_nxt      = g;
    cnt_nxt    = cnt;
    rr_ptr_nxt = rr_ptr;
    case (state)
      IDLE: begin
        if (pick_found) begin
          g_nxt     = pick_idx;
          cnt_nxt   = '0;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (rempty[g]) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = g_succ;
        end else if (space) begin
          if (cnt == CNT_LAST) begin
            state_nxt  = IDLE;
            rr_ptr_nxt = g_succ;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state  <= IDLE;
      g      <= '0;
      cnt    <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      g      <= g_nxt;
      cnt    <= cnt_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  // Output register: loads on a pop, drains on accept, otherwise holds.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_chan  <= '0;
    end else if (pop) begin
      m_valid <= 1'b1;
      m_data  <= chan_data[g];
      m_chan  <= g;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  for (genvar i = 0; i < NCH; i++) begin : g_stats
    logic [STAT_W-1:0] pops;
    always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
        pops <= '0;
      end else if (rout[i] && (pops != {STAT_W{1'b1}})) begin
        pops <= pops + 1'b1;
      end
    end
    assign pop_cnt[i*STAT_W +: STAT_W] = pops;
  end
`endif

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Directed bench for fifo_read_arbiter: behavioural FIFOs feed the DUT, a sink logs accepted words.
module tb_fifo_read_arbiter;

  localparam int NCH   = 4;
  localparam int DSIZE = 8;
  localparam int BURST = 4;

  logic                   rclk = 1'b0;
  logic                   rrst_n;
  logic [NCH-1:0]         rempty;
  logic [NCH*DSIZE-1:0]   rdata;
  logic [NCH-1:0]         rout;
  logic                   m_valid;
  logic                   m_ready;
  logic [DSIZE-1:0]       m_data;
  logic [$clog2(NCH)-1:0] m_chan;
`ifdef FIFO_ARB_STATS_EN
  logic [NCH*16-1:0]      pop_cnt;
`endif

  fifo_read_arbiter #(.NCH(NCH), .DSIZE(DSIZE), .BURST(BURST)) dut (
    .rclk    (rclk),
    .rrst_n  (rrst_n),
    .rempty  (rempty),
    .rdata   (rdata),
    .rout    (rout),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_chan  (m_chan)
`ifdef FIFO_ARB_STATS_EN
    ,
    .pop_cnt (pop_cnt)
`endif
  );

  always #5 rclk = ~rclk;

  logic [7:0] fq [NCH][$];
  int wr_idx [NCH];
  int rx_ch[$];
  int rx_dat[$];
  int pop_ch[$];
  int pop_cyc[$];
  int cyc = 0;
  int n_pop = 0;
  int viol = 0;
  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < NCH; i++) begin
      rempty[i] = (fq[i].size() == 0);
      rdata[i*DSIZE +: DSIZE] = rempty[i] ? 8'h00 : fq[i][0];
    end
  endtask

  task automatic push(input int ch, input int n);
    for (int k = 0; k < n; k++) begin
      fq[ch].push_back(8'(ch * 16 + wr_idx[ch]));
      wr_idx[ch]++;
    end
    refresh();
  endtask

  task automatic clear_logs();
    rx_ch.delete();
    rx_dat.delete();
    pop_ch.delete();
    pop_cyc.delete();
    n_pop = 0;
  endtask

  task automatic do_reset();
    rrst_n  = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      fq[i].delete();
      wr_idx[i] = 0;
    end
    refresh();
    clear_logs();
    repeat (2) @(negedge rclk);
    rrst_n = 1'b1;
  endtask

  task automatic wait_rx(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (rx_ch.size() < n && k < budget) begin
      @(negedge rclk);
      k++;
    end
    check(tag, rx_ch.size(), n);
  endtask

  // FIFO model and sink: pops on rout, logs accepted words, flags illegal pop strobes.
  always @(posedge rclk) begin
    cyc++;
    if ($countones(rout) > 1 || (rout & rempty) != '0) viol++;
    if (m_valid && m_ready) begin
      rx_ch.push_back(int'(m_chan));
      rx_dat.push_back(int'(m_data));
    end
    for (int i = 0; i < NCH; i++) begin
      if (rout[i] && fq[i].size() > 0) begin
        void'(fq[i].pop_front());
        pop_ch.push_back(i);
        pop_cyc.push_back(cyc);
        n_pop++;
      end
    end
    #1 refresh();
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int quiet;
    int off [10];
    int held;
    int stall_bad;
    int p2;
    int c1;

    // Reset state with all FIFOs empty
    rrst_n  = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < NCH; i++) wr_idx[i] = 0;
    refresh();
    #1;
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_rout", int'(rout), 0);
    check("rst_m_data", int'(m_data), 0);
    check("rst_m_chan", int'(m_chan), 0);
    do_reset();
    quiet = 0;
    repeat (20) begin
      @(negedge rclk);
      if (m_valid || rout != '0) quiet++;
    end
    check("idle_quiet", quiet, 0);

    // Single channel, 10 words: bursts of 4,4,2 with one idle cycle between
    do_reset();
    @(negedge rclk);
    push(0, 10);
    wait_rx(10, 100, "b10_count");
    off = '{0, 1, 2, 3, 5, 6, 7, 8, 10, 11};
    for (int k = 0; k < 10; k++) begin
      check($sformatf("b10_chan%0d", k), rx_ch[k], 0);
      check($sformatf("b10_data%0d", k), rx_dat[k], k);
      check($sformatf("b10_popcyc%0d", k), pop_cyc[k] - pop_cyc[0], off[k]);
    end
    check("b10_valid_drained", int'(m_valid), 0);

    // Two channels, 8 words each: grant order 0,2,0,2
    do_reset();
    @(negedge rclk);
    push(0, 8);
    push(2, 8);
    wait_rx(16, 200, "rr_count");
    for (int k = 0; k < 16; k++) begin
      check($sformatf("rr_chan%0d", k), rx_ch[k], ((k / 4) % 2 == 0) ? 0 : 2);
      check($sformatf("rr_data%0d", k), rx_dat[k],
            (((k / 4) % 2 == 0) ? 0 : 32) + (k / 8) * 4 + (k % 4));
    end

    // Backpressure for 5 cycles mid-burst
    do_reset();
    @(negedge rclk);
    push(1, 8);
    wait_rx(2, 50, "bp_pre_count");
    m_ready = 1'b0;
    held = int'(m_data);
    check("bp_held_word", held, 8'h12);
    stall_bad = 0;
    repeat (5) begin
      @(negedge rclk);
      if (rout != '0 || !m_valid || int'(m_data) != held || (n_pop - rx_ch.size()) != 1)
        stall_bad++;
    end
    check("bp_stall", stall_bad, 0);
    m_ready = 1'b1;
    wait_rx(8, 100, "bp_count");
    for (int k = 0; k < 8; k++) check($sformatf("bp_data%0d", k), rx_dat[k], 16 + k);
    check("bp_pops", n_pop, 8);

    // Channel empties early: next search starts at ch2
    do_reset();
    @(negedge rclk);
    push(1, 2);
    wait_rx(2, 50, "early_pre_count");
    push(0, 1);
    push(2, 1);
    wait_rx(4, 50, "early_count");
    check("early_ch0", rx_ch[0], 1);
    check("early_ch1", rx_ch[1], 1);
    check("early_ch2", rx_ch[2], 2);
    check("early_ch3", rx_ch[3], 0);
    c1 = 0;
    foreach (pop_ch[k]) if (pop_ch[k] == 1) c1++;
    check("early_ch1_pops", c1, 2);

    // Reset mid-burst: outputs clear at once, arbitration restarts at ch0
    do_reset();
    @(negedge rclk);
    push(1, 4);
    wait_rx(4, 50, "mr_pre1");
    push(2, 8);
    wait_rx(6, 50, "mr_pre2");
    rrst_n = 1'b0;
    #1;
    check("mr_m_valid", int'(m_valid), 0);
    check("mr_rout", int'(rout), 0);
    check("mr_m_chan", int'(m_chan), 0);
    check("mr_m_data", int'(m_data), 0);
    p2 = 0;
    foreach (pop_ch[k]) if (pop_ch[k] == 2) p2++;
    push(0, 1);
    clear_logs();
    repeat (2) @(negedge rclk);
    rrst_n = 1'b1;
    wait_rx(2, 50, "mr_count");
    check("mr_first_chan", rx_ch[0], 0);
    check("mr_first_data", rx_dat[0], 0);
    check("mr_next_chan", rx_ch[1], 2);
    check("mr_next_data", rx_dat[1], 32 + p2);

    check("rout_rules", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_read_arbiter.md
FIFO_READ_ARBITER -- requirements
Module: fifo_read_arbiter

Interface
REQ-001 Parameter NCH, default 4: number of async-FIFO read ports arbitrated (2..8).
REQ-002 Parameter DSIZE, default 8: data width per FIFO.
REQ-003 Parameter BURST, default 4: max pops per grant (1..16).
REQ-004 rclk  input  1  read-domain clock.
REQ-005 rrst_n  input  1  reset, asynchronous, active-low.
REQ-006 rempty  input  NCH  per-FIFO empty flag, registered in rclk domain by the FIFO.
REQ-007 rdata  input  NCH*DSIZE  per-FIFO head word, channel i at bits [i*DSIZE +: DSIZE], valid when rempty[i]=0.
REQ-008 rout  output  NCH  per-FIFO pop strobe, at most one bit high per cycle.
REQ-009 m_valid  output  1  output word valid.
REQ-010 m_ready  input  1  downstream accepts the word when m_valid=1 and m_ready=1.
REQ-011 m_data  output  DSIZE  output word.
REQ-012 m_chan  output  clog2(NCH)  source channel of m_data.

Function
REQ-013 FSM states SHALL be IDLE and GRANT; grant register g and burst counter cnt (clog2(BURST)+1 bits) SHALL be held.
REQ-014 IDLE: if any rempty[i]=0, select the first non-empty channel searching upward from rr_ptr modulo NCH; load g, clear cnt, go to GRANT next cycle; otherwise stay in IDLE.
REQ-015 Define space = !m_valid || m_ready.
REQ-016 GRANT: rout[g] = !rempty[g] && space, combinational; all other rout bits 0.
REQ-017 On the pop cycle, m_data <= rdata[g], m_chan <= g, m_valid <= 1 at the next edge, giving 1-cycle pop-to-valid latency.
REQ-018 If m_ready=1 and no pop occurs, m_valid SHALL go 0; while m_valid=1 and m_ready=0, m_data and m_chan SHALL be held stable.
REQ-019 GRANT: on a pop with cnt=BURST-1, go to IDLE and set rr_ptr <= (g+1) mod NCH; otherwise cnt increments.
REQ-020 GRANT: if rempty[g]=1, go to IDLE with rr_ptr <= (g+1) mod NCH and no pop.
REQ-021 GRANT with backpressure (rempty[g]=0, space=0): remain, no pop, cnt unchanged.
REQ-022 Every IDLE visit SHALL cost exactly one cycle between grants; peak throughput is BURST words per BURST+1 cycles.
REQ-023 Fairness: a continuously non-empty channel SHALL be granted within NCH-1 other grants.
REQ-024 rout SHALL never assert for a channel whose rempty=1.

Reset
REQ-025 Async assertion of rrst_n=0: state=IDLE, rr_ptr=0, g=0, cnt=0, m_valid=0, m_data=0, m_chan=0, rout=0 combinationally.
REQ-026 Reset mid-burst SHALL discard the in-flight output word; FIFO contents already popped are lost by design.
REQ-027 Deassertion is taken synchronously to rclk via the team's standard reset synchronizer upstream.

Configuration
REQ-028 Macro FIFO_ARB_STATS_EN defined: adds output pop_cnt (NCH*16 bits), per-channel 16-bit saturating pop counters, incremented on each rout[i], saturating at 16'hFFFF, reset to 0.
REQ-029 Macro undefined: pop_cnt port and counters SHALL be absent; all other behaviour is identical.

Structure
REQ-030 Shared package fifo_arb_pkg SHALL hold the state enum (IDLE, GRANT) and the counter-width constant STAT_W=16.
REQ-031 Sub-module rr_pick (combinational rotate-priority selector: request vector and pointer in, index and found flag out) SHALL implement REQ-014.

Verification
REQ-032 Reset only, all rempty=1 -> m_valid=0, rout=0 for 20 cycles.
REQ-033 NCH=4, BURST=4, ch0 holds 10 words, m_ready=1 -> pops ch0 4,4,2 with one IDLE cycle between bursts; 10 words in order, m_chan=0.
REQ-034 Ch0 and ch2 each hold 8 words, rr_ptr=0 -> grant order 0,2,0,2; each burst 4 words.
REQ-035 m_ready=0 for 5 cycles mid-burst -> m_data stable, exactly one word outstanding, no rout; resume -> no loss or duplicate.
REQ-036 Ch1 empties after 2 pops of a burst -> IDLE, rr_ptr=2, no pop of ch1 while rempty[1]=1.
REQ-037 rrst_n pulsed low mid-burst -> m_valid=0 and rout=0 immediately; after release, arbitration restarts from ch0.
